// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared types, pad constants and padder state encoding
package sha256_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [511:0] block_t;

  localparam word_t PAD_WORD = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRESENT,
    ST_FINISH
  } pad_state_t;

  // One word for the 0x80000000 marker plus two for the 64-bit length.
  function automatic int num_blocks(input int n);
    return ((n + 2) / 16) + 1;
  endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// rtl/sha256_pad_word.sv - maps a global padded-word index to its value
module sha256_pad_word
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 30
) (
  input  word_t i_g,
  input  word_t i_mem_data,
  output word_t o_word
);

  localparam word_t N_W      = word_t'(NUM_OF_WORDS);
  localparam word_t LEN_IDX  = word_t'(16 * num_blocks(NUM_OF_WORDS) - 1);
  localparam word_t LEN_BITS = word_t'(NUM_OF_WORDS * 32);

  // The high length word is always zero, so it falls into the default branch.
  always_comb begin
    if (i_g < N_W)          o_word = i_mem_data;
    else if (i_g == N_W)    o_word = PAD_WORD;
    else if (i_g == LEN_IDX) o_word = LEN_BITS;
    else                    o_word = '0;
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// rtl/sha256_msg_padder.sv - reads a message from SRAM and emits padded 512-bit blocks
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int NUM_OF_WORDS = 30
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [15:0]  message_addr,
  output logic         busy,
  output logic         done,
  output logic         mem_we,
  output logic [15:0]  mem_addr,
  input  logic [31:0]  mem_read_data,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic [511:0] blk_data,
  output logic [7:0]   blk_idx,
  output logic         blk_last
);

  localparam int          NUM_BLOCKS = num_blocks(NUM_OF_WORDS);
  localparam logic [11:0] LAST_BLK   = 12'(NUM_BLOCKS - 1);
  localparam word_t       N_W        = word_t'(NUM_OF_WORDS);

  pad_state_t  r_state;
  logic [15:0] r_base;
  logic [11:0] r_blk;
  logic [4:0]  r_slot;
  logic        r_t1_vld;
  logic        r_t2_vld;
  word_t       r_t1_g;
  word_t       r_t2_g;

  logic        w_handshake;
  logic        w_iss_vld;
  logic [11:0] w_iss_blk;
  logic [3:0]  w_iss_slot;
  logic [15:0] w_iss_base;
  word_t       w_iss_g;
  logic        w_iss_mem;
  word_t       w_pad;
  logic [8:0]  w_wr_lsb;

  assign mem_we      = 1'b0;
  assign blk_idx     = r_blk[7:0];
  assign w_handshake = blk_valid & blk_ready;

  // Slot 0 of a block is issued on the very edge that enters FETCH.
  always_comb begin
    w_iss_vld  = 1'b0;
    w_iss_blk  = r_blk;
    w_iss_slot = r_slot[3:0];
    w_iss_base = r_base;
    unique case (r_state)
      ST_IDLE: if (start) begin
        w_iss_vld  = 1'b1;
        w_iss_blk  = '0;
        w_iss_slot = '0;
        w_iss_base = message_addr;
      end
      ST_FETCH: w_iss_vld = (r_slot < 5'd16);
      ST_PRESENT: if (w_handshake && !blk_last) begin
        w_iss_vld  = 1'b1;
        w_iss_blk  = r_blk + 12'd1;
        w_iss_slot = '0;
      end
      default: ;
    endcase
  end

  assign w_iss_g   = {16'b0, w_iss_blk, w_iss_slot};
  assign w_iss_mem = w_iss_vld && (w_iss_g < N_W);
  assign w_wr_lsb  = {~r_t2_g[3:0], 5'b0};

  sha256_pad_word #(.NUM_OF_WORDS(NUM_OF_WORDS)) u_pad_word (
    .i_g        (r_t2_g),
    .i_mem_data (mem_read_data),
    .o_word     (w_pad)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_base    <= '0;
      r_blk     <= '0;
      r_slot    <= '0;
      r_t1_vld  <= 1'b0;
      r_t2_vld  <= 1'b0;
      r_t1_g    <= '0;
      r_t2_g    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_addr  <= '0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      blk_data  <= '0;
    end else begin
      done     <= 1'b0;
      r_t1_vld <= w_iss_vld;
      r_t1_g   <= w_iss_g;
      r_t2_vld <= r_t1_vld;
      r_t2_g   <= r_t1_g;
      if (w_iss_mem) mem_addr <= w_iss_base + w_iss_g[15:0];
      // Two edges after issue the SRAM data for that slot is on mem_read_data.
      if (r_t2_vld) blk_data[w_wr_lsb +: 32] <= w_pad;

      unique case (r_state)
        ST_IDLE: if (start) begin
          r_base  <= message_addr;
          busy    <= 1'b1;
          r_blk   <= '0;
          r_slot  <= 5'd1;
          r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (r_slot == 5'd17) begin
            blk_valid <= 1'b1;
            blk_last  <= (r_blk == LAST_BLK);
            r_state   <= ST_PRESENT;
          end else begin
            r_slot <= r_slot + 5'd1;
          end
        end
        ST_PRESENT: if (w_handshake) begin
          blk_valid <= 1'b0;
          blk_last  <= 1'b0;
          if (blk_last) begin
            r_state <= ST_FINISH;
          end else begin
            r_blk   <= r_blk + 12'd1;
            r_slot  <= 5'd1;
            r_state <= ST_FETCH;
          end
        end
        ST_FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb/tb_sha256_msg_padder.sv - randomized self-checking bench for three padder instances
module tb_sha256_msg_padder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] message_addr;

  logic         busy_s      [3];
  logic         done_s      [3];
  logic         mem_we_s    [3];
  logic [15:0]  mem_addr_s  [3];
  logic [31:0]  rdata_s     [3];
  logic         blk_valid_s [3];
  logic         blk_ready_s [3];
  logic [511:0] blk_data_s  [3];
  logic [7:0]   blk_idx_s   [3];
  logic         blk_last_s  [3];

  logic [31:0] mem [0:65535];

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int nw(input int k);
    return (k == 0) ? 30 : (k == 1) ? 13 : 14;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int NK = (k == 0) ? 30 : (k == 1) ? 13 : 14;
    sha256_msg_padder #(.NUM_OF_WORDS(NK)) u_dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .message_addr  (message_addr),
      .busy          (busy_s[k]),
      .done          (done_s[k]),
      .mem_we        (mem_we_s[k]),
      .mem_addr      (mem_addr_s[k]),
      .mem_read_data (rdata_s[k]),
      .blk_valid     (blk_valid_s[k]),
      .blk_ready     (blk_ready_s[k]),
      .blk_data      (blk_data_s[k]),
      .blk_idx       (blk_idx_s[k]),
      .blk_last      (blk_last_s[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) rdata_s[k] <= mem[mem_addr_s[k]];
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the padded message as a flat word queue per instance.
  logic [31:0]  q       [3][$];
  logic [511:0] cap     [3][8];
  bit           armed   [3];
  int           since   [3];
  int           fin     [3];
  int           exp_idx [3];
  bit           prev_v  [3];
  logic [15:0]  prev_a  [3];
  int           nblk    [3];
  int           ndone   [3];
  int           vcnt    [3];

  initial begin
    for (int k = 0; k < 3; k++) begin
      nblk[k] = 0;
      ndone[k] = 0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset_n) begin
        armed[k] = 0; since[k] = 0; fin[k] = -1; exp_idx[k] = 0;
        prev_v[k] = 0; prev_a[k] = '0;
      end else begin
        logic [511:0] eb;
        int nb;
        nb = q[k].size() / 16;
        if (armed[k]) since[k]++;
        if (fin[k] >= 0) fin[k]++;
        check($sformatf("mem_we[%0d]", k), 512'(mem_we_s[k]), 512'(0));
        check($sformatf("done[%0d]", k), 512'(done_s[k]), 512'(fin[k] == 2));
        if (fin[k] >= 2) fin[k] = -1;
        if (done_s[k]) ndone[k]++;
        if (blk_valid_s[k]) begin
          if (!prev_v[k]) begin
            check($sformatf("latency[%0d]", k), 512'(armed[k] ? since[k] : -1), 512'(17));
            armed[k] = 0;
          end
          for (int w = 0; w < 16; w++)
            eb[511 - 32*w -: 32] = (16*exp_idx[k] + w < q[k].size()) ? q[k][16*exp_idx[k] + w] : 32'hDEAD_BEEF;
          check($sformatf("blk_data[%0d]", k), blk_data_s[k], eb);
          check($sformatf("blk_idx[%0d]", k), 512'(blk_idx_s[k]), 512'(exp_idx[k]));
          check($sformatf("blk_last[%0d]", k), 512'(blk_last_s[k]), 512'(exp_idx[k] == nb - 1));
          check($sformatf("busy_in_blk[%0d]", k), 512'(busy_s[k]), 512'(1));
          if (prev_v[k]) check($sformatf("mem_addr_hold[%0d]", k), 512'(mem_addr_s[k]), 512'(prev_a[k]));
          if (blk_ready_s[k]) begin
            nblk[k]++;
            if (exp_idx[k] < 8) cap[k][exp_idx[k]] = blk_data_s[k];
            if (exp_idx[k] == nb - 1) fin[k] = 0;
            else begin
              armed[k] = 1;
              since[k] = -1;
            end
            exp_idx[k]++;
          end
        end
        if (start && !busy_s[k]) begin
          q[k].delete();
          for (int i = 0; i < nw(k); i++) q[k].push_back(mem[message_addr + 16'(i)]);
          q[k].push_back(32'h8000_0000);
          while (q[k].size() % 16 != 14) q[k].push_back(32'h0);
          q[k].push_back(32'h0);
          q[k].push_back(32'(nw(k) * 32));
          armed[k] = 1;
          since[k] = -1;
          exp_idx[k] = 0;
        end
        prev_v[k] = blk_valid_s[k];
        prev_a[k] = mem_addr_s[k];
      end
    end
  end

  task automatic tick(input int mode);
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (blk_valid_s[k]) vcnt[k]++;
      else vcnt[k] = 0;
      case (mode)
        0:       blk_ready_s[k] = 1'b1;
        1:       blk_ready_s[k] = ($urandom_range(0, 2) != 0);
        default: blk_ready_s[k] = (vcnt[k] > 10);
      endcase
    end
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_busy", 512'(busy_s[k]), 512'(0));
    check("rst_done", 512'(done_s[k]), 512'(0));
    check("rst_valid", 512'(blk_valid_s[k]), 512'(0));
    check("rst_last", 512'(blk_last_s[k]), 512'(0));
    check("rst_mem_we", 512'(mem_we_s[k]), 512'(0));
    check("rst_mem_addr", 512'(mem_addr_s[k]), 512'(0));
    check("rst_idx", 512'(blk_idx_s[k]), 512'(0));
    check("rst_data", blk_data_s[k], 512'(0));
  endtask

  task automatic run_msg(input logic [15:0] a, input int mode, input bit inj, input bit abort);
    bit finished;
    finished = 0;
    start = 1'b1;
    message_addr = a;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick(mode);
      if (cyc == 0) start = 1'b0;
      if (inj && cyc == 5) begin
        start = 1'b1;
        message_addr = a ^ 16'h1234;
      end
      if (inj && cyc == 6) start = 1'b0;
      if (abort && busy_s[0] && blk_idx_s[0] == 8'd1 && !blk_valid_s[0]) begin
        #2 reset_n = 1'b0;
        #1 check_reset_outputs(0);
        tick(mode);
        tick(mode);
        reset_n = 1'b1;
        return;
      end
      if (cyc > 0 && !busy_s[0] && !busy_s[1] && !busy_s[2]) begin
        finished = 1;
        break;
      end
    end
    check("run_complete", 512'(finished), 512'(1));
    tick(mode);
    tick(mode);
  endtask

  task automatic run_and_tally(input logic [15:0] a, input int mode, input bit inj);
    int b0 [3];
    int d0 [3];
    for (int k = 0; k < 3; k++) begin
      b0[k] = nblk[k];
      d0[k] = ndone[k];
    end
    run_msg(a, mode, inj, 1'b0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("blocks[%0d]", k), 512'(nblk[k] - b0[k]), 512'(q[k].size() / 16));
      check($sformatf("done_count[%0d]", k), 512'(ndone[k] - d0[k]), 512'(1));
    end
  endtask

  initial begin
    int d_abort;
    reset_n = 1'b0;
    start = 1'b0;
    message_addr = '0;
    for (int k = 0; k < 3; k++) begin
      blk_ready_s[k] = 1'b0;
      vcnt[k] = 0;
    end
    for (int i = 0; i < 65536; i++) mem[i] = $urandom;
    mem[0] = 32'h0123_4675;
    for (int i = 1; i < 30; i++) mem[i] = {mem[i-1][30:0], mem[i-1][31]};

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset_outputs(k);
    reset_n = 1'b1;
    tick(0);

    run_and_tally(16'h0000, 0, 1'b0);
    check("n30_b0_w0", 512'(cap[0][0][511:480]), 512'(32'h0123_4675));
    check("n30_b1_w14", 512'(cap[0][1][63:32]), 512'(32'h8000_0000));
    check("n30_b1_w15", 512'(cap[0][1][31:0]), 512'(0));
    check("n30_b2_upper", 512'(cap[0][2][511:32]), 512'(0));
    check("n30_b2_w15", 512'(cap[0][2][31:0]), 512'(960));
    check("n13_w13", 512'(cap[1][0][95:64]), 512'(32'h8000_0000));
    check("n13_w14", 512'(cap[1][0][63:32]), 512'(0));
    check("n13_w15", 512'(cap[1][0][31:0]), 512'(416));
    check("n14_b0_w14", 512'(cap[2][0][63:32]), 512'(32'h8000_0000));
    check("n14_b0_w15", 512'(cap[2][0][31:0]), 512'(0));
    check("n14_b1_upper", 512'(cap[2][1][511:32]), 512'(0));
    check("n14_b1_w15", 512'(cap[2][1][31:0]), 512'(448));

    run_and_tally(16'h0000, 2, 1'b0);
    run_and_tally(16'h0000, 0, 1'b1);

    d_abort = ndone[0];
    run_msg(16'h0000, 0, 1'b0, 1'b1);
    tick(0);
    tick(0);
    check("abort_no_done", 512'(ndone[0] - d_abort), 512'(0));
    run_and_tally(16'h0000, 0, 1'b0);

    for (int r = 0; r < 8; r++)
      run_and_tally(16'($urandom_range(0, 65500)), (r % 2 == 0) ? 1 : 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
